// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit datapath.
// It registers the decoded operands and control signals, and turns ALUOp/funct
// into the 4-bit ALU control code. It forwards from EX/MEM and MEM/WB to drive
// the ALU operands combinationally, and it inserts a bubble on a load-use hazard.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_uses_rt,
  input  logic [1:0]        id_alu_op,
  input  logic [3:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              exm_reg_write,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] store_data,
  output logic [RA_W-1:0]   ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch
);

  // Registered state that is not visible directly on the ports
  logic              ex_alu_src_reg;
  logic [RA_W-1:0]   rs_reg;
  logic [RA_W-1:0]   rt_reg;
  logic [DATA_W-1:0] rs_data_reg;
  logic [DATA_W-1:0] rt_data_reg;
  logic [DATA_W-1:0] imm_reg;

  logic [3:0]        alu_control_next;
  logic [RA_W-1:0]   dest_next;
  logic              bubble;
  logic              load_en;

  // Translate ALUOp/funct into the ALU control code at decode time
  always_comb begin
    alu_control_next = 4'b1111;
    case (id_alu_op)
      2'b00: alu_control_next = 4'b0010;
      2'b01: alu_control_next = 4'b0110;
      2'b11: alu_control_next = 4'b0001;
      default: begin
        case (id_funct)
          4'd0:    alu_control_next = 4'b0010;
          4'd1:    alu_control_next = 4'b0110;
          4'd2:    alu_control_next = 4'b0000;
          4'd3:    alu_control_next = 4'b0001;
          4'd4:    alu_control_next = 4'b1100;
          4'd5:    alu_control_next = 4'b1101;
          4'd6:    alu_control_next = 4'b0111;
          default: alu_control_next = 4'b1111;
        endcase
      end
    endcase
  end

  assign dest_next = id_reg_dst ? id_rd : id_rt;

  // A load in EX whose target is a source of the instruction in decode.
  // This depends only on the decode inputs and the stage contents.
  assign load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_dest != '0) &
                          ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

  // flush overrides hold. A stall only inserts a bubble when the stage is not frozen.
  assign bubble  = flush | (~hold & load_use_stall);
  assign load_en = flush | ~hold;

  // Pipeline register update: bubble, hold, or capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_branch      <= 1'b0;
      ex_alu_src_reg <= 1'b0;
      alu_control    <= 4'b0000;
      ex_dest        <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
    end else if (load_en) begin
      if (bubble) begin
        ex_valid       <= 1'b0;
        ex_reg_write   <= 1'b0;
        ex_mem_read    <= 1'b0;
        ex_mem_write   <= 1'b0;
        ex_mem_to_reg  <= 1'b0;
        ex_branch      <= 1'b0;
        ex_alu_src_reg <= 1'b0;
        alu_control    <= 4'b0000;
        ex_dest        <= '0;
        rs_reg         <= '0;
        rt_reg         <= '0;
        rs_data_reg    <= '0;
        rt_data_reg    <= '0;
        imm_reg        <= '0;
      end else begin
        ex_valid       <= id_valid;
        ex_reg_write   <= id_reg_write;
        ex_mem_read    <= id_mem_read;
        ex_mem_write   <= id_mem_write;
        ex_mem_to_reg  <= id_mem_to_reg;
        ex_branch      <= id_branch;
        ex_alu_src_reg <= id_alu_src;
        alu_control    <= alu_control_next;
        ex_dest        <= dest_next;
        rs_reg         <= id_rs;
        rt_reg         <= id_rt;
        rs_data_reg    <= id_rs_data;
        rt_data_reg    <= id_rt_data;
        imm_reg        <= id_imm;
      end
    end
  end

  // Operand forwarding. Index 0 is rs and index 1 is rt.
  // EX/MEM has priority over MEM/WB, and register 0 is never forwarded.
  logic [RA_W-1:0]   src_addr [2];
  logic [DATA_W-1:0] src_data [2];
  logic [DATA_W-1:0] fwd_data [2];

  assign src_addr[0] = rs_reg;
  assign src_addr[1] = rt_reg;
  assign src_data[0] = rs_data_reg;
  assign src_data[1] = rt_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // Choose the newest in-flight value for this source register
      always_comb begin
        fwd_data[gi] = src_data[gi];
        if (exm_reg_write && (exm_rd != '0) && (exm_rd == src_addr[gi]))
          fwd_data[gi] = exm_result;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src_addr[gi]))
          fwd_data[gi] = wb_result;
      end
    end
  endgenerate

  assign alu_a      = fwd_data[0];
  assign store_data = fwd_data[1];
  assign alu_b      = ex_alu_src_reg ? imm_reg : fwd_data[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage.
// Expected stage contents are queued when a decode is presented and checked
// after the capturing edge. Forwarding, hazard and reset cases are checked directly.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        flush;
  logic        id_valid;
  logic [15:0] id_rs_data;
  logic [15:0] id_rt_data;
  logic [15:0] id_imm;
  logic [1:0]  id_rs;
  logic [1:0]  id_rt;
  logic [1:0]  id_rd;
  logic        id_uses_rt;
  logic [1:0]  id_alu_op;
  logic [3:0]  id_funct;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_branch;
  logic        exm_reg_write;
  logic [1:0]  exm_rd;
  logic [15:0] exm_result;
  logic        wb_reg_write;
  logic [1:0]  wb_rd;
  logic [15:0] wb_result;
  logic        load_use_stall;
  logic        ex_valid;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_control;
  logic [15:0] store_data;
  logic [1:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_branch;

  id_ex_stage #(.DATA_W(16), .RA_W(2)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .alu_a(alu_a),
    .alu_b(alu_b), .alu_control(alu_control), .store_data(store_data),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  ctl;
    logic [1:0]  dest;
    logic        rw, mr, mw, m2r, br;
    logic [15:0] a, b, sd;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_txn   = 0;

  // Single comparison point: count it and report a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU control table
  function automatic logic [3:0] ctl_model(input logic [1:0] op, input logic [3:0] fn);
    logic [3:0] rtab [8];
    rtab[0] = 4'b0010; rtab[1] = 4'b0110; rtab[2] = 4'b0000; rtab[3] = 4'b0001;
    rtab[4] = 4'b1100; rtab[5] = 4'b1101; rtab[6] = 4'b0111; rtab[7] = 4'b1111;
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    if (fn < 4'd8) return rtab[fn[2:0]];
    return 4'b1111;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_alu_op = 0; id_funct = 0;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0; id_branch = 0;
  endtask

  task automatic clear_fwd();
    exm_reg_write = 0; exm_rd = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  // Queue what a plain capture of the current decode inputs must produce
  task automatic push_capture();
    exp_t e;
    e.v   = id_valid;
    e.ctl = ctl_model(id_alu_op, id_funct);
    e.dest = id_reg_dst ? id_rd : id_rt;
    e.rw = id_reg_write; e.mr = id_mem_read; e.mw = id_mem_write;
    e.m2r = id_mem_to_reg; e.br = id_branch;
    e.a  = id_rs_data;
    e.b  = id_alu_src ? id_imm : id_rt_data;
    e.sd = id_rt_data;
    sb.push_back(e);
    last_exp = e;
  endtask

  task automatic push_bubble();
    exp_t e;
    e.v = 0; e.ctl = 0; e.dest = 0; e.rw = 0; e.mr = 0; e.mw = 0;
    e.m2r = 0; e.br = 0; e.a = 0; e.b = 0; e.sd = 0;
    sb.push_back(e);
    last_exp = e;
  endtask

  // Pop the oldest expectation and compare it against the stage outputs
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = sb.pop_front();
    n_txn++;
    $display("[TB] txn %0d: v=%0d ctl=%b dest=%0d a=%h b=%h sd=%h",
             n_txn, ex_valid, alu_control, ex_dest, alu_a, alu_b, store_data);
    check("ex_valid", ex_valid, e.v);
    check("alu_control", alu_control, e.ctl);
    check("ex_dest", ex_dest, e.dest);
    check("ex_reg_write", ex_reg_write, e.rw);
    check("ex_mem_read", ex_mem_read, e.mr);
    check("ex_mem_write", ex_mem_write, e.mw);
    check("ex_mem_to_reg", ex_mem_to_reg, e.m2r);
    check("ex_branch", ex_branch, e.br);
    check("alu_a", alu_a, e.a);
    check("alu_b", alu_b, e.b);
    check("store_data", store_data, e.sd);
  endtask

  initial begin
    reset = 1; hold = 0; flush = 0;
    clear_id();
    clear_fwd();
    #12;
    // Reset state
    check("rst_ex_valid", ex_valid, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_ex_dest", ex_dest, 0);
    check("rst_ex_reg_write", ex_reg_write, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_store_data", store_data, 0);
    check("rst_stall", load_use_stall, 0);
    @(negedge clk);
    reset = 0;

    // add r2 = r1 + r2
    id_valid = 1; id_alu_op = 2'b10; id_funct = 0; id_rs_data = 16'h0005;
    id_rt_data = 16'h0003; id_rs = 1; id_rt = 2; id_rd = 2; id_reg_dst = 1;
    id_reg_write = 1; id_uses_rt = 1;
    push_capture();
    tick();
    check_out();

    // ALU control decode across all ALUOp / funct cases
    for (int i = 0; i < 12; i++) begin
      clear_id();
      id_valid     = 1'($urandom_range(0, 1));
      id_alu_op    = (i < 9) ? 2'b10 : (i == 9) ? 2'b00 : (i == 10) ? 2'b01 : 2'b11;
      id_funct     = (i < 8) ? 4'(i) : (i == 8) ? 4'd15 : 4'($urandom_range(0, 15));
      id_rs_data   = 16'($urandom_range(0, 65535));
      id_rt_data   = 16'($urandom_range(0, 65535));
      id_imm       = 16'($urandom_range(0, 65535));
      id_rs        = 2'($urandom_range(0, 3));
      id_rt        = 2'($urandom_range(0, 3));
      id_rd        = 2'($urandom_range(0, 3));
      id_reg_dst   = 1'($urandom_range(0, 1));
      id_alu_src   = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_write = 1'($urandom_range(0, 1));
      id_mem_to_reg = 1'($urandom_range(0, 1));
      id_branch    = 1'($urandom_range(0, 1));
      push_capture();
      tick();
      check_out();
    end

    // Forwarding priority on a captured rs=1, rt=2 instruction
    clear_id();
    id_valid = 1; id_alu_op = 2'b10; id_rs = 1; id_rt = 2; id_rd = 3; id_reg_dst = 1;
    id_rs_data = 16'h1111; id_rt_data = 16'h2222; id_reg_write = 1; id_uses_rt = 1;
    push_capture();
    tick();
    check_out();
    clear_id();
    exm_reg_write = 1; exm_rd = 1; exm_result = 16'h1234;
    wb_reg_write = 1; wb_rd = 1; wb_result = 16'hBEEF;
    #1;
    check("fwd_exm_alu_a", alu_a, 16'h1234);
    check("fwd_exm_rt_untouched", store_data, 16'h2222);
    exm_reg_write = 0;
    #1;
    check("fwd_wb_alu_a", alu_a, 16'hBEEF);
    wb_rd = 2;
    #1;
    check("fwd_wb_store_data", store_data, 16'hBEEF);
    check("fwd_wb_alu_b", alu_b, 16'hBEEF);
    check("fwd_wb_rs_none", alu_a, 16'h1111);
    clear_fwd();
    tick();
    check("fwd_none_alu_a", alu_a, 16'h0000);

    // Register 0 is never forwarded
    clear_id();
    id_valid = 1; id_alu_op = 2'b10; id_rs = 0; id_rt = 3; id_rs_data = 0;
    id_rt_data = 16'h0033; id_uses_rt = 1;
    exm_reg_write = 1; exm_rd = 0; exm_result = 16'h5555;
    wb_reg_write = 1; wb_rd = 0; wb_result = 16'h6666;
    push_capture();
    tick();
    check_out();
    clear_fwd();

    // Load-use hazard: lw r3 followed by a dependent instruction
    clear_id();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_imm = 16'h0004; id_rs = 1;
    id_rt = 3; id_reg_dst = 0; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
    id_rs_data = 16'h0100;
    push_capture();
    tick();
    check_out();
    clear_id();
    id_valid = 1; id_alu_op = 2'b10; id_rs = 1; id_rt = 3; id_rd = 2; id_reg_dst = 1;
    id_reg_write = 1; id_uses_rt = 0; id_rs_data = 16'h0007; id_rt_data = 16'h0009;
    #1;
    check("stall_rt_unused", load_use_stall, 0);
    id_uses_rt = 1;
    #1;
    check("stall_rt_used", load_use_stall, 1);
    id_uses_rt = 0; id_rs = 3; id_rt = 1;
    #1;
    check("stall_rs", load_use_stall, 1);
    push_bubble();
    tick();
    check_out();
    check("stall_released", load_use_stall, 0);
    push_capture();
    tick();
    check_out();

    // Hold keeps the stage intact for three cycles
    hold = 1;
    id_rs_data = 16'hDEAD; id_funct = 4'd4; id_rd = 1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(last_exp);
      tick();
      check_out();
    end
    // Flush wins over hold
    flush = 1;
    push_bubble();
    tick();
    check_out();
    hold = 0; flush = 0;

    // sw r2, 4(r1) with MEM/WB forwarding into store data
    clear_id();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_imm = 16'h0004; id_rs = 1;
    id_rt = 2; id_uses_rt = 1; id_mem_write = 1; id_rs_data = 16'h0010;
    id_rt_data = 16'h0002;
    push_capture();
    tick();
    check_out();
    wb_reg_write = 1; wb_rd = 2; wb_result = 16'h00AA;
    #1;
    check("sw_alu_b", alu_b, 16'h0004);
    check("sw_store_data", store_data, 16'h00AA);
    check("sw_alu_control", alu_control, 4'b0010);
    clear_fwd();

    // beq
    clear_id();
    id_valid = 1; id_alu_op = 2'b01; id_branch = 1; id_uses_rt = 1; id_rs = 1; id_rt = 2;
    id_rs_data = 16'h0042; id_rt_data = 16'h0042;
    push_capture();
    tick();
    check_out();

    // Asynchronous reset mid-cycle with a valid instruction in stage
    #2;
    reset = 1;
    #1;
    check("arst_ex_valid", ex_valid, 0);
    check("arst_alu_control", alu_control, 0);
    check("arst_ex_branch", ex_branch, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_store_data", store_data, 0);
    @(negedge clk);
    reset = 0;
    // First edge after deassertion captures
    clear_id();
    id_valid = 1; id_alu_op = 2'b11; id_rs = 2; id_rt = 1; id_rd = 1; id_reg_dst = 1;
    id_reg_write = 1; id_rs_data = 16'h0F0F; id_rt_data = 16'h3030; id_uses_rt = 1;
    push_capture();
    tick();
    check_out();

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
